// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_pkg
// Description : Shared types and helpers for the FIFO-fed UART blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    localparam logic IDLE_LEVEL = 1'b1;

    // One extra bit so the counter can hold DATA_W itself.
    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Free-running bit-period counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bit_end = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Pops words from a synchronous FIFO and sends them as 8N1
//               UART frames, LSB first. Define FIFO_UART_TX_PARITY_EN to add
//               an even-parity bit between the data and stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy
);

    localparam int c_bit_w = bit_cnt_w(DATA_W);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_W - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    localparam state_t c_after_data = PARITY;
`else
    localparam state_t c_after_data = STOP;
`endif

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_next;
    logic [c_bit_w-1:0]  r_bit_cnt;
    logic [c_bit_w-1:0]  w_bit_cnt_next;
    logic                r_tx;
    logic                w_tx_next;
    logic                w_bit_end;
    logic                w_clear;

`ifdef FIFO_UART_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (r_state == WAIT) begin
            r_parity <= ^fifo_data;
        end
    end
`endif

    // Restart the bit period on every state change.
    assign w_clear = (w_state_next != r_state);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .bit_end (w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= IDLE_LEVEL;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tx      <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        case (r_state)
            IDLE:  if (tx_en && !fifo_empty) w_state_next = POP;
            POP:   w_state_next = WAIT;
            WAIT: begin
                w_state_next = START;
                w_shift_next = fifo_data;
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next   = DATA;
                    w_bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_next   = r_shift >> 1;
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == c_last_bit) w_state_next = c_after_data;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: if (w_bit_end) w_state_next = STOP;
`endif
            STOP:  if (w_bit_end) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        // Line level is computed from the next state so tx comes straight off a flop.
        w_tx_next = IDLE_LEVEL;
        case (w_state_next)
            START:  w_tx_next = ~IDLE_LEVEL;
            DATA:   w_tx_next = w_shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: w_tx_next = r_parity;
`endif
            default: w_tx_next = IDLE_LEVEL;
        endcase
    end

    assign tx         = r_tx;
    assign fifo_rd_en = (r_state == POP);
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Scoreboard bench for fifo_uart_tx with a registered FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0] d;
        bit         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic [7:0] fifo_data;
    wire        fifo_empty;
    wire        fifo_rd_en;
    wire        tx;
    wire        busy;

    logic [7:0] mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         cyc = 0;

    exp_t       exp_mem [0:15];
    int         exp_wr = 0;
    int         exp_rd = 0;

    int         total = 0;
    int         bad = 0;
    int         pop_cnt = 0;
    int         last_pop_cyc = -100;
    int         last_end_cyc = -100;
    int         frames_done = 0;
    int         abort_req = 0;

    fifo_uart_tx #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Synchronous FIFO model: read data registered one cycle after the pop.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [7:0] word, input bit gap);
        exp_mem[exp_wr] = '{d: word, gap: gap};
        exp_wr++;
        mem[wr_ptr] = word;
        wr_ptr++;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames_done < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frame_wait", int'(frames_done >= n), 1);
    endtask

    task automatic wait_tx_low(input int budget);
        int k = 0;
        while (!(tx == 1'b0 && !rst) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("start_wait", int'(tx == 1'b0), 1);
    endtask

    // Frame monitor: consumes one scoreboard entry per start bit seen.
    initial begin : mon
        exp_t          e;
        logic [NB-1:0] fr;
        int            s;
        int            abort_seen;
        bit            ab;
        abort_seen = 0;
        forever begin
            @(negedge clk);
            if (!rst && tx == 1'b0) begin
                s = cyc;
                check("frame_expected", int'(exp_wr != exp_rd), 1);
                if (exp_wr != exp_rd) begin
                    e = exp_mem[exp_rd];
                    exp_rd++;
                    fr        = '0;
                    fr[DW:1]  = e.d;
`ifdef FIFO_UART_TX_PARITY_EN
                    fr[DW+1]  = ^e.d;
`endif
                    fr[NB-1]  = 1'b1;
                    check("pop_to_start", s - last_pop_cyc, 2);
                    if (e.gap) check("frame_gap", s - last_end_cyc - 1, 3);
                    ab = 1'b0;
                    for (int i = 0; i < NB * CPB; i++) begin
                        if (i > 0) @(negedge clk);
                        if (abort_req != abort_seen) begin
                            abort_seen = abort_req;
                            ab = 1'b1;
                            break;
                        end
                        check("tx_busy", {tx, busy}, {fr[i / CPB], 1'b1});
                    end
                    if (!ab) begin
                        last_end_cyc = cyc;
                        @(negedge clk);
                        check("busy_after", int'(busy), 0);
                        frames_done++;
                    end
                end
            end
        end
    end

    initial begin : popmon
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && fifo_rd_en) begin
                pop_cnt++;
                last_pop_cyc = cyc;
                check("pop_nonempty", int'(fifo_empty), 0);
                check("pop_single", int'(prev), 0);
            end
            prev = fifo_rd_en && !rst;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_rd_en", int'(fifo_rd_en), 0);

        // Empty FIFO with tx enabled: line stays idle, no pops.
        tx_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_line", {tx, busy}, 2'b10);
        end
        check("idle_pops", pop_cnt, 0);

        // Single frame 0xA5.
        push(8'hA5, 1'b0);
        wait_frames(1, 200);
        check("a5_pops", pop_cnt, 1);

        // Back-to-back 0x01, 0xFF.
        @(negedge clk);
        push(8'h01, 1'b0);
        push(8'hFF, 1'b1);
        wait_frames(3, 300);
        check("b2b_pops", pop_cnt, 3);

        // tx_en dropped during START with two words queued.
        @(negedge clk);
        push(8'h5A, 1'b0);
        push(8'hC3, 1'b0);
        wait_tx_low(50);
        tx_en = 1'b0;
        wait_frames(4, 200);
        repeat (40) @(negedge clk);
        check("txen_pops", pop_cnt, 4);
        check("txen_fifo_left", wr_ptr - rd_ptr, 1);
        check("txen_idle", int'(busy), 0);
        tx_en = 1'b1;
        wait_frames(5, 200);
        check("txen_resume_pops", pop_cnt, 5);

        // Reset pulse in DATA bit 3 of 0x3C.
        @(negedge clk);
        push(8'h3C, 1'b0);
        wait_tx_low(50);
        repeat (17) @(negedge clk);
        @(posedge clk);
        #1;
        abort_req = abort_req + 1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_tx", int'(tx), 1);
        check("rst_mid_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("post_rst_line", {tx, busy}, 2'b10);
        end
        check("post_rst_pops", pop_cnt, 6);
        check("frames_total", frames_done, 5);
        check("sb_drained", exp_wr - exp_rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
